// File: rtl/hollywood_candidate_source_if.sv
// Beat stream from the candidate source into an unhash core.
interface hollywood_candidate_source_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_channel;
  logic [15:0] out_data;

  modport master (
    output out_valid,
    output out_channel,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_channel,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/hollywood_candidate_source.sv
// Brute-force candidate generator: per candidate sends a clear (mgmt) beat, the
// candidate words, waits for the core compare, then samples the match flag.
module hollywood_candidate_source #(
  parameter int unsigned NUM_WORDS   = 2,
  parameter logic [7:0]  CHAR_MIN    = 8'h41,
  parameter logic [7:0]  CHAR_MAX    = 8'h5A,
  parameter int unsigned RESULT_WAIT = 2,
  parameter bit          STOP_ON_HIT = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  hollywood_candidate_source_if.master  stream,
  input  logic                          match_in,
  output logic                          hit_valid,
  output logic [16*NUM_WORDS-1:0]       hit_data,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   cand_count
);

  localparam int unsigned NumChars = 2 * NUM_WORDS;
  localparam int unsigned IdxW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned WaitW    = $clog2(RESULT_WAIT);

  typedef enum logic [2:0] {StIdle, StMgmt, StData, StWait, StCheck, StDone} state_e;

  state_e                     state_q, state_d;
  logic [NumChars-1:0][7:0]   chars_q, chars_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [WaitW-1:0]           wait_q, wait_d;
  logic [31:0]                count_q, count_d;
  logic                       stop_pend_q, stop_pend_d;

  logic                       valid, channel, hit, carry, exhausted, stop_req;
  logic [15:0]                data;
  logic [16*NUM_WORDS-1:0]    cand;

  // Char c[i] sits at bits [8i+7:8i], so word k = {c[2k+1], c[2k]} falls out directly.
  assign cand     = chars_q;
  // A stop seen while a beat was stalled is remembered until that beat goes out.
  assign stop_req = stop | stop_pend_q;

  assign stream.out_valid   = valid;
  assign stream.out_channel = channel;
  assign stream.out_data    = data;
  assign hit_valid          = hit;
  assign hit_data           = hit ? cand : '0;
  assign cand_count         = count_q;

  // Space is exhausted when every char position sits at CHAR_MAX.
  always_comb begin
    exhausted = 1'b1;
    for (int i = 0; i < NumChars; i++) begin
      if (chars_q[i] != CHAR_MAX) exhausted = 1'b0;
    end
  end

  // Next-state, odometer and output decode.
  always_comb begin
    state_d     = state_q;
    chars_d     = chars_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q;
    valid       = 1'b0;
    channel     = 1'b0;
    data        = 16'h0000;
    hit         = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    carry       = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d     = StMgmt;
          chars_d     = {NumChars{CHAR_MIN}};
          count_d     = '0;
          stop_pend_d = 1'b0;
        end
      end
      StMgmt: begin
        valid   = 1'b1;
        channel = 1'b1;
        if (stream.out_ready) begin
          if (stop_req) begin
            state_d = StDone;
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      StData: begin
        valid = 1'b1;
        data  = cand[{idx_q, 4'b0000} +: 16];
        if (stream.out_ready) begin
          if (stop_req) begin
            state_d = StDone;
          end else if (idx_q == IdxW'(NUM_WORDS - 1)) begin
            state_d = StWait;
            wait_d  = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      StWait: begin
        if (stop_req) begin
          state_d = StDone;
        end else if (wait_q == WaitW'(RESULT_WAIT - 1)) begin
          state_d = StCheck;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StCheck: begin
        if (stop_req) begin
          state_d = StDone;
        end else begin
          if (count_q != '1) count_d = count_q + 32'd1;
          hit = match_in;
          if (exhausted || (match_in && STOP_ON_HIT)) begin
            state_d = StDone;
          end else begin
            state_d = StMgmt;
            // Odometer step, c[0] fastest.
            for (int i = 0; i < NumChars; i++) begin
              if (carry) begin
                if (chars_q[i] == CHAR_MAX) begin
                  chars_d[i] = CHAR_MIN;
                end else begin
                  chars_d[i] = chars_q[i] + 8'd1;
                  carry      = 1'b0;
                end
              end
            end
          end
        end
      end
      StDone: begin
        busy        = 1'b0;
        done        = 1'b1;
        stop_pend_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any in-flight beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      chars_q     <= {NumChars{CHAR_MIN}};
      idx_q       <= '0;
      wait_q      <= '0;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chars_q     <= chars_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      stop_pend_q <= stop_pend_d;
    end
  end

endmodule

// File: tb/tb_hollywood_candidate_source.sv
// Bench: instance A (2 words, chars 41..43) runs a randomized full enumeration
// against a reference model; instance B (1 word, chars 30..31, stop-on-hit)
// runs a cycle table plus an exhaustion sequence.
module tb_hollywood_candidate_source;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  localparam int AW = 2, AR = 2, ABASE = 3, ATOTAL = 81;
  hollywood_candidate_source_if bus_a ();
  logic        start_a, stop_a, match_a, hit_valid_a, busy_a, done_a;
  logic [31:0] hit_data_a, count_a;

  hollywood_candidate_source #(
    .NUM_WORDS(AW), .CHAR_MIN(8'h41), .CHAR_MAX(8'h43), .RESULT_WAIT(AR), .STOP_ON_HIT(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .stream(bus_a),
    .match_in(match_a), .hit_valid(hit_valid_a), .hit_data(hit_data_a),
    .busy(busy_a), .done(done_a), .cand_count(count_a)
  );

  // ---------------- instance B ----------------
  hollywood_candidate_source_if bus_b ();
  logic        start_b, stop_b, match_b, hit_valid_b, busy_b, done_b;
  logic [15:0] hit_data_b;
  logic [31:0] count_b;

  hollywood_candidate_source #(
    .NUM_WORDS(1), .CHAR_MIN(8'h30), .CHAR_MAX(8'h31), .RESULT_WAIT(3), .STOP_ON_HIT(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .stream(bus_b),
    .match_in(match_b), .hit_valid(hit_valid_b), .hit_data(hit_data_b),
    .busy(busy_b), .done(done_b), .cand_count(count_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Candidate n of instance A as base-3 digits, c[0] least significant.
  function automatic logic [15:0] a_word(input int n, input int k);
    int p, lo, hi;
    p = 1;
    for (int i = 0; i < 2 * k; i++) p = p * ABASE;
    lo = (n / p) % ABASE;
    hi = (n / (p * ABASE)) % ABASE;
    return {8'(65 + hi), 8'(65 + lo)};
  endfunction

  function automatic logic [31:0] a_cand(input int n);
    return {a_word(n, 1), a_word(n, 0)};
  endfunction

  // ---------------- reference model monitor for A ----------------
  bit          mon_en = 1'b0;
  int          m_cand = 0, m_beat = 0, m_wait = 0, m_count = 0;
  bit          m_done_due = 1'b0, m_prev_stall = 1'b0, m_in_check = 1'b0;
  logic        m_prev_ch = 1'b0;
  logic [15:0] m_prev_data = 16'h0;
  logic [16:0] m_exp_beat;

  // Each negedge: compare DUT against the expected beat sequence and check timing.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_prev_stall) begin
        check("stall_valid", bus_a.out_valid, 1'b1);
        check("stall_beat", {bus_a.out_channel, bus_a.out_data}, {m_prev_ch, m_prev_data});
      end
      m_in_check = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_in_check = 1'b1;
      end
      check("rand_done", done_a, m_done_due);
      m_done_due = 1'b0;
      check("rand_count", count_a, m_count);
      check("rand_hit_valid", hit_valid_a, m_in_check && match_a);
      if (m_in_check) begin
        if (match_a) check("rand_hit_data", hit_data_a, a_cand(m_cand));
        m_count++;
        if (m_cand == ATOTAL - 1) m_done_due = 1'b1;
        else begin
          m_cand++;
          m_beat = 0;
        end
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        checks++;
        if (m_beat > AW) begin
          errors++;
          $display("FAIL rand_extra_beat actual %h required none", {bus_a.out_channel, bus_a.out_data});
        end else begin
          m_exp_beat = (m_beat == 0) ? {1'b1, 16'h0000} : {1'b0, a_word(m_cand, m_beat - 1)};
          if ({bus_a.out_channel, bus_a.out_data} !== m_exp_beat) begin
            errors++;
            $display("FAIL rand_beat actual %h required %h", {bus_a.out_channel, bus_a.out_data},
                     m_exp_beat);
          end
          m_beat++;
          if (m_beat == AW + 1) m_wait = AR + 1;
        end
      end
      m_prev_stall = bus_a.out_valid && !bus_a.out_ready;
      m_prev_ch    = bus_a.out_channel;
      m_prev_data  = bus_a.out_data;
    end
  end

  // ---------------- table for B ----------------
  typedef struct {
    bit st, sp, rd, mt;
    bit vl, ch; logic [15:0] d;
    bit h; logic [15:0] hd;
    bit dn, bs; int cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit st, sp, rd, mt, vl, ch, input logic [15:0] d, input bit h,
                     input logic [15:0] hd, input bit dn, bs, input int cnt);
    vec_t v;
    v = '{st, sp, rd, mt, vl, ch, d, h, hd, dn, bs, cnt};
    vecs.push_back(v);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got[$];
    logic [15:0] exp_t2[4];
    bit          seen;

    reset = 1'b1;
    start_a = 0; stop_a = 0; match_a = 0; bus_a.out_ready = 0;
    start_b = 0; stop_b = 0; match_b = 0; bus_b.out_ready = 0;

    // st sp rd mt | vl ch data | hit hdata | done busy count
    add(1, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);  // IDLE, start
    add(0, 0, 1, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 1, 0);  // MGMT
    add(0, 0, 1, 0, 1, 0, 16'h3030, 0, 16'h0000, 0, 1, 0);  // DATA
    add(0, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);  // WAIT, match ignored
    add(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);  // CHECK, no match
    add(0, 0, 1, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 1, 1);  // MGMT
    add(0, 0, 1, 0, 1, 0, 16'h3031, 0, 16'h0000, 0, 1, 1);  // DATA
    add(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 1);
    add(0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h3031, 0, 1, 1);  // CHECK, hit
    add(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 2);  // DONE (stop on hit)
    add(0, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2);  // IDLE, stop ignored
    add(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus_a.out_valid, 1'b0);
    check("rst_data", {bus_a.out_channel, bus_a.out_data}, 17'h0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_hit", {hit_valid_a, hit_data_a}, 33'h0);
    check("rst_count", count_a, 32'd0);
    reset = 1'b0;

    // Cycle table on B.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      start_b = vecs[i].st; stop_b = vecs[i].sp;
      bus_b.out_ready = vecs[i].rd; match_b = vecs[i].mt;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), bus_b.out_valid, vecs[i].vl);
      check($sformatf("vec%0d_beat", i), {bus_b.out_channel, bus_b.out_data},
            {vecs[i].ch, vecs[i].d});
      check($sformatf("vec%0d_hit", i), {hit_valid_b, hit_data_b}, {vecs[i].h, vecs[i].hd});
      check($sformatf("vec%0d_done", i), done_b, vecs[i].dn);
      check($sformatf("vec%0d_busy", i), busy_b, vecs[i].bs);
      check($sformatf("vec%0d_count", i), count_b, 32'(vecs[i].cnt));
    end

    // Full exhaustion on B with no matches.
    exp_t2[0] = 16'h3030; exp_t2[1] = 16'h3031; exp_t2[2] = 16'h3130; exp_t2[3] = 16'h3131;
    @(posedge clk); #1;
    start_b = 1; stop_b = 0; match_b = 0; bus_b.out_ready = 1;
    @(posedge clk); #1;
    start_b = 0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus_b.out_valid && bus_b.out_ready && !bus_b.out_channel) got.push_back(bus_b.out_data);
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    check("t2_done_seen", seen, 1'b1);
    check("t2_ncand", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check($sformatf("t2_cand%0d", i), got[i], exp_t2[i]);
    check("t2_count", count_b, 32'd4);
    check("t2_busy", busy_b, 1'b0);

    // Randomized full enumeration on A against the reference model.
    @(posedge clk); #1;
    mon_en = 1'b1;
    start_a = 1;
    seen = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      start_a = 0;
      bus_a.out_ready = ($urandom_range(0, 9) < 7);
      match_a = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    mon_en = 1'b0;
    bus_a.out_ready = 1; match_a = 0;
    check("rand_done_seen", seen, 1'b1);
    check("rand_final_count", count_a, 32'(ATOTAL));
    check("rand_final_busy", busy_a, 1'b0);

    // Stop asserted in WAIT of the second candidate.
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("stop_in_wait_valid", bus_a.out_valid, 1'b0);
    check("stop_in_wait_busy", busy_a, 1'b1);
    stop_a = 1;
    @(negedge clk);
    check("stop_done", done_a, 1'b1);
    check("stop_count", count_a, 32'd1);
    @(posedge clk); #1;
    stop_a = 0;
    @(negedge clk);
    check("stop_idle_busy", busy_a, 1'b0);
    check("stop_idle_done", done_a, 1'b0);

    // Reset in the middle of a data beat.
    @(posedge clk); #1;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pre_rst_beat", {bus_a.out_valid, bus_a.out_channel, bus_a.out_data}, {2'b10, 16'h4142});
    check("pre_rst_count", count_a, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", bus_a.out_valid, 1'b0);
    check("mid_rst_beat", {bus_a.out_channel, bus_a.out_data}, 17'h0);
    check("mid_rst_status", {busy_a, done_a, hit_valid_a}, 3'b000);
    check("mid_rst_count", count_a, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    @(negedge clk);
    check("post_rst_mgmt", {bus_a.out_valid, bus_a.out_channel, bus_a.out_data}, {2'b11, 16'h0});
    @(negedge clk);
    check("post_rst_word0", {bus_a.out_valid, bus_a.out_channel, bus_a.out_data}, {2'b10, 16'h4141});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
